// File: rtl/fa_response_checker_pkg.sv
// rtl/fa_response_checker_pkg.sv - shared types and constants for the full-adder response checker
package fa_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    // One coverage bit per {a,b,cin} combination.
    localparam int NUM_VEC = 8;

    // first_fail packs {a,b,cin,sum,carry}.
    localparam int FF_W = 5;

    function automatic logic [NUM_VEC-1:0] vec_onehot(input logic [2:0] idx);
        logic [NUM_VEC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/fa_response_checker_if.sv
// rtl/fa_response_checker_if.sv - stimulus/observation and result bundle between a driver and the checker
interface fa_response_checker_if #(
    parameter int CNT_W = 16
);
    import fa_chk_pkg::*;

    logic                 start;
    logic                 vld;
    logic                 a;
    logic                 b;
    logic                 cin;
    logic                 sum;
    logic                 carry;

    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 fail;
    logic [CNT_W-1:0]     vec_cnt;
    logic [CNT_W-1:0]     err_cnt;
    logic [NUM_VEC-1:0]   cov;
    logic [FF_W-1:0]      first_fail;

    modport master (
        output start, vld, a, b, cin, sum, carry,
        input  busy, done, pass, fail, vec_cnt, err_cnt, cov, first_fail
    );

    modport slave (
        input  start, vld, a, b, cin, sum, carry,
        output busy, done, pass, fail, vec_cnt, err_cnt, cov, first_fail
    );

endinterface

// File: rtl/fa_response_checker_ref.sv
// rtl/fa_response_checker_ref.sv - combinational golden full-adder model
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic exp_sum,
    output logic exp_carry
);

    logic half_sum;

    always_comb begin
        half_sum  = a ^ b;
        exp_sum   = half_sum ^ cin;
        exp_carry = (a & b) | (cin & half_sum);
    end

endmodule

// File: rtl/fa_response_checker.sv
// rtl/fa_response_checker.sv - checks full-adder responses against the golden model, tracks coverage and errors
module fa_response_checker
    import fa_chk_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    fa_response_checker_if.slave  bus
);

    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [NUM_VEC-1:0] COV_ALL = {NUM_VEC{1'b1}};

    chk_state_e         state_q;
    chk_state_e         state_d;

    logic [CNT_W-1:0]   vec_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [NUM_VEC-1:0] cov_q;
    logic [FF_W-1:0]    first_fail_q;
    logic               fail_q;

    logic [2:0]         vec_idx;
    logic               exp_sum;
    logic               exp_carry;
    logic               mismatch;
    logic               sample;
    logic [NUM_VEC-1:0] cov_upd;
    logic               run_complete;

    logic               busy_c;
    logic               done_c;
    logic               pass_c;

    assign vec_idx = {bus.a, bus.b, bus.cin};

    fa_ref_model u_ref (
        .a         (bus.a),
        .b         (bus.b),
        .cin       (bus.cin),
        .exp_sum   (exp_sum),
        .exp_carry (exp_carry)
    );

    // A start in the same cycle as vld wins, so that sample is dropped.
    always_comb begin
        mismatch     = (bus.sum != exp_sum) || (bus.carry != exp_carry);
        sample       = (state_q == RUN) && bus.vld && !bus.start;
        cov_upd      = cov_q | vec_onehot(vec_idx);
        run_complete = (cov_upd == COV_ALL) || (STOP_ON_FAIL && mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.start) begin
                    state_d = RUN;
                end else if (sample && run_complete) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // pass is decoded only from registered state and results.
    always_comb begin
        busy_c = (state_q == RUN);
        done_c = (state_q == DONE);
        pass_c = done_c && (err_cnt_q == '0) && (cov_q == COV_ALL);
    end

    // Results are cleared by every start, whatever the current state.
    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            cov_q        <= '0;
            first_fail_q <= '0;
            fail_q       <= 1'b0;
        end else if (sample) begin
            if (vec_cnt_q != CNT_MAX) begin
                vec_cnt_q <= vec_cnt_q + 1'b1;
            end
            cov_q <= cov_upd;
            if (mismatch) begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                fail_q <= 1'b1;
                if (!fail_q) begin
                    first_fail_q <= {vec_idx, bus.sum, bus.carry};
                end
            end
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.pass       = pass_c;
    assign bus.fail       = fail_q;
    assign bus.vec_cnt    = vec_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.cov        = cov_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_fa_response_checker.sv
// tb/tb_fa_response_checker.sv - directed self-checking bench for fa_response_checker
module tb_fa_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fa_response_checker_if #(.CNT_W(16)) bus0 ();
    fa_response_checker_if #(.CNT_W(16)) bus1 ();
    fa_response_checker_if #(.CNT_W(3))  bus2 ();

    fa_response_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fa_response_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fa_response_checker #(.CNT_W(3),  .STOP_ON_FAIL(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int n_vec = 0;
    int n_bad = 0;

    // Correct adder outputs indexed by {a,b,cin}.
    logic [7:0] sum_tbl   = 8'b1001_0110;
    logic [7:0] carry_tbl = 8'b1110_1000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic st, input logic v, input logic [2:0] abc,
                         input logic s, input logic c);
        case (u)
            0: begin
                bus0.start = st; bus0.vld = v; {bus0.a, bus0.b, bus0.cin} = abc;
                bus0.sum = s; bus0.carry = c;
            end
            1: begin
                bus1.start = st; bus1.vld = v; {bus1.a, bus1.b, bus1.cin} = abc;
                bus1.sum = s; bus1.carry = c;
            end
            default: begin
                bus2.start = st; bus2.vld = v; {bus2.a, bus2.b, bus2.cin} = abc;
                bus2.sum = s; bus2.carry = c;
            end
        endcase
    endtask

    task automatic idle_all;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic good(input int u, input logic [2:0] abc);
        drive(u, 1'b0, 1'b1, abc, sum_tbl[abc], carry_tbl[abc]);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        n_vec++;
        if ({bus0.busy, bus0.done, bus0.pass, bus0.fail, bus0.vec_cnt, bus0.err_cnt, bus0.cov, bus0.first_fail} !== '0) begin
            n_bad++; $display("FAIL reset_u0: busy=%b done=%b vec=%0d cov=%h", bus0.busy, bus0.done, bus0.vec_cnt, bus0.cov);
        end
        n_vec++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.fail, bus1.vec_cnt, bus1.err_cnt, bus1.cov, bus1.first_fail} !== '0) begin
            n_bad++; $display("FAIL reset_u1: busy=%b done=%b vec=%0d cov=%h", bus1.busy, bus1.done, bus1.vec_cnt, bus1.cov);
        end
        n_vec++;
        if ({bus2.busy, bus2.done, bus2.pass, bus2.fail, bus2.vec_cnt, bus2.err_cnt, bus2.cov, bus2.first_fail} !== '0) begin
            n_bad++; $display("FAIL reset_u2: busy=%b done=%b vec=%0d cov=%h", bus2.busy, bus2.done, bus2.vec_cnt, bus2.cov);
        end
        rst = 1'b0;
        good(0, 3'd1);
        tick();
        idle_all();
        n_vec++;
        if ({bus0.busy, bus0.vec_cnt} !== 17'd0) begin
            n_bad++; $display("FAIL idle_ignores_vld: busy=%b vec=%0d want 0/0", bus0.busy, bus0.vec_cnt);
        end
    endtask

    task automatic test_clean_run;
        drive(0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        n_vec++;
        if ({bus0.busy, bus0.done, bus0.vec_cnt} !== {1'b1, 1'b0, 16'd0}) begin
            n_bad++; $display("FAIL start_busy: busy=%b done=%b vec=%0d want 1/0/0", bus0.busy, bus0.done, bus0.vec_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            good(0, 3'(i));
            tick();
            if (i == 6) begin
                n_vec++;
                if ({bus0.busy, bus0.done, bus0.cov} !== {1'b1, 1'b0, 8'h7F}) begin
                    n_bad++; $display("FAIL clean_7th: busy=%b done=%b cov=%h want 1/0/7f", bus0.busy, bus0.done, bus0.cov);
                end
            end
        end
        idle_all();
        n_vec++;
        if ({bus0.done, bus0.pass, bus0.busy, bus0.fail} !== 4'b1100) begin
            n_bad++; $display("FAIL clean_flags: done=%b pass=%b busy=%b fail=%b want 1/1/0/0", bus0.done, bus0.pass, bus0.busy, bus0.fail);
        end
        n_vec++;
        if ({bus0.vec_cnt, bus0.err_cnt, bus0.cov} !== {16'd8, 16'd0, 8'hFF}) begin
            n_bad++; $display("FAIL clean_counts: vec=%0d err=%0d cov=%h want 8/0/ff", bus0.vec_cnt, bus0.err_cnt, bus0.cov);
        end
        good(0, 3'd3);
        tick();
        idle_all();
        n_vec++;
        if ({bus0.done, bus0.vec_cnt} !== {1'b1, 16'd8}) begin
            n_bad++; $display("FAIL done_ignores_vld: done=%b vec=%0d want 1/8", bus0.done, bus0.vec_cnt);
        end
    endtask

    task automatic test_single_fault;
        drive(0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        n_vec++;
        if ({bus0.busy, bus0.done, bus0.pass, bus0.vec_cnt, bus0.cov} !== {3'b100, 16'd0, 8'h00}) begin
            n_bad++; $display("FAIL restart_clear: busy=%b done=%b pass=%b vec=%0d cov=%h", bus0.busy, bus0.done, bus0.pass, bus0.vec_cnt, bus0.cov);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 5) drive(0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
            else        good(0, 3'(i));
            tick();
        end
        idle_all();
        n_vec++;
        if ({bus0.done, bus0.pass, bus0.fail} !== 3'b101) begin
            n_bad++; $display("FAIL fault_flags: done=%b pass=%b fail=%b want 1/0/1", bus0.done, bus0.pass, bus0.fail);
        end
        n_vec++;
        if ({bus0.err_cnt, bus0.vec_cnt, bus0.first_fail} !== {16'd1, 16'd8, 5'b10110}) begin
            n_bad++; $display("FAIL fault_capture: err=%0d vec=%0d first_fail=%b want 1/8/10110", bus0.err_cnt, bus0.vec_cnt, bus0.first_fail);
        end
    endtask

    task automatic test_incomplete;
        drive(0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            good(0, 3'(i % 6));
            tick();
        end
        idle_all();
        n_vec++;
        if ({bus0.busy, bus0.done, bus0.fail} !== 3'b100) begin
            n_bad++; $display("FAIL partial_flags: busy=%b done=%b fail=%b want 1/0/0", bus0.busy, bus0.done, bus0.fail);
        end
        n_vec++;
        if ({bus0.vec_cnt, bus0.err_cnt, bus0.cov} !== {16'd12, 16'd0, 8'h3F}) begin
            n_bad++; $display("FAIL partial_counts: vec=%0d err=%0d cov=%h want 12/0/3f", bus0.vec_cnt, bus0.err_cnt, bus0.cov);
        end
    endtask

    task automatic test_restart_drop;
        drive(0, 1'b1, 1'b1, 3'd6, sum_tbl[6], carry_tbl[6]);
        tick();
        idle_all();
        n_vec++;
        if ({bus0.busy, bus0.vec_cnt, bus0.cov} !== {1'b1, 16'd0, 8'h00}) begin
            n_bad++; $display("FAIL start_drops_vld: busy=%b vec=%0d cov=%h want 1/0/00", bus0.busy, bus0.vec_cnt, bus0.cov);
        end
    endtask

    task automatic test_reset_mid_run;
        for (int i = 0; i < 4; i++) begin
            good(0, 3'(i));
            tick();
        end
        n_vec++;
        if (bus0.vec_cnt !== 16'd4) begin
            n_bad++; $display("FAIL pre_reset_vec: vec=%0d want 4", bus0.vec_cnt);
        end
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 3'd4, sum_tbl[4], carry_tbl[4]);
        tick();
        rst = 1'b0;
        idle_all();
        n_vec++;
        if ({bus0.busy, bus0.done, bus0.pass, bus0.fail, bus0.vec_cnt, bus0.err_cnt, bus0.cov, bus0.first_fail} !== '0) begin
            n_bad++; $display("FAIL reset_mid_run: busy=%b done=%b vec=%0d cov=%h want all 0", bus0.busy, bus0.done, bus0.vec_cnt, bus0.cov);
        end
        drive(0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 7; i >= 0; i--) begin
            good(0, 3'(i));
            tick();
        end
        idle_all();
        n_vec++;
        if ({bus0.pass, bus0.done, bus0.vec_cnt} !== {2'b11, 16'd8}) begin
            n_bad++; $display("FAIL rerun_pass: pass=%b done=%b vec=%0d want 1/1/8", bus0.pass, bus0.done, bus0.vec_cnt);
        end
    endtask

    task automatic test_stop_on_fail;
        drive(1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        good(1, 3'd0);
        tick();
        good(1, 3'd1);
        tick();
        n_vec++;
        if ({bus1.busy, bus1.done, bus1.vec_cnt} !== {2'b10, 16'd2}) begin
            n_bad++; $display("FAIL stop_before: busy=%b done=%b vec=%0d want 1/0/2", bus1.busy, bus1.done, bus1.vec_cnt);
        end
        drive(1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
        tick();
        idle_all();
        n_vec++;
        if ({bus1.done, bus1.busy, bus1.pass, bus1.fail} !== 4'b1001) begin
            n_bad++; $display("FAIL stop_flags: done=%b busy=%b pass=%b fail=%b want 1/0/0/1", bus1.done, bus1.busy, bus1.pass, bus1.fail);
        end
        n_vec++;
        if ({bus1.vec_cnt, bus1.err_cnt, bus1.first_fail} !== {16'd3, 16'd1, 5'b01011}) begin
            n_bad++; $display("FAIL stop_counts: vec=%0d err=%0d first_fail=%b want 3/1/01011", bus1.vec_cnt, bus1.err_cnt, bus1.first_fail);
        end
        for (int i = 3; i < 8; i++) begin
            good(1, 3'(i));
            tick();
        end
        idle_all();
        n_vec++;
        if ({bus1.done, bus1.vec_cnt, bus1.cov} !== {1'b1, 16'd3, 8'h07}) begin
            n_bad++; $display("FAIL stop_holds: done=%b vec=%0d cov=%h want 1/3/07", bus1.done, bus1.vec_cnt, bus1.cov);
        end
    endtask

    task automatic test_saturation;
        drive(2, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(2, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
            tick();
        end
        idle_all();
        n_vec++;
        if ({bus2.vec_cnt, bus2.err_cnt} !== {3'd7, 3'd7}) begin
            n_bad++; $display("FAIL sat_counts: vec=%0d err=%0d want 7/7", bus2.vec_cnt, bus2.err_cnt);
        end
        n_vec++;
        if ({bus2.first_fail, bus2.cov, bus2.fail, bus2.busy} !== {5'b00010, 8'h01, 2'b11}) begin
            n_bad++; $display("FAIL sat_state: first_fail=%b cov=%h fail=%b busy=%b want 00010/01/1/1", bus2.first_fail, bus2.cov, bus2.fail, bus2.busy);
        end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_clean_run();
        test_single_fault();
        test_incomplete();
        test_restart_drop();
        test_reset_mid_run();
        test_stop_on_fail();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
